// File: rtl/mtm_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mtm_alu_pkg
// Brief    : Shared MTM ALU constants: serializer state encodings, frame
//            levels, flag positions, error-byte layout and CRC3 step.
// Revision : 1.0 - initial release
// ============================================================================
package mtm_alu_pkg;

    // Gray-coded serializer states; neighbouring states differ by one bit
    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_START = 3'b001;
    localparam logic [2:0] S_TYPE  = 3'b011;
    localparam logic [2:0] S_DATA  = 3'b010;
    localparam logic [2:0] S_STOP  = 3'b110;
    localparam logic [2:0] S_GAP   = 3'b111;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;
    localparam logic TYPE_DATA = 1'b0;
    localparam logic TYPE_CTRL = 1'b1;

    localparam int FRAME_LEN  = 11;
    localparam int RES_FRAMES = 5;

    localparam int FLAG_CARRY    = 3;
    localparam int FLAG_OVERFLOW = 2;
    localparam int FLAG_ZERO     = 1;
    localparam int FLAG_NEGATIVE = 0;

    localparam int ERR_MARK_POS   = 7;
    localparam int ERR_CRC_LSB    = 5;
    localparam int ERR_OP_LSB     = 3;
    localparam int ERR_DATA_LSB   = 1;
    localparam int ERR_PARITY_POS = 0;

    typedef struct packed {
        logic       mark;
        logic [1:0] crc;
        logic [1:0] op;
        logic [1:0] data;
        logic       parity;
    } err_byte_t;

    // x^3 + x + 1, leading term implicit
    localparam logic [2:0] CRC3_POLY = 3'b011;
    localparam int         CRC_MSG_W = 37;

    function automatic logic [2:0] crc3_step(input logic [2:0] crc, input logic d);
        logic fb;
        fb = crc[2] ^ d;
        return {crc[1:0], 1'b0} ^ ({3{fb}} & CRC3_POLY);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mtm_alu_crc3.sv
`default_nettype none
// ============================================================================
// Module   : mtm_alu_crc3
// Brief    : Combinational CRC3 (x^3+x+1, init 0) over an MSB-first message.
// Revision : 1.0 - initial release
// ============================================================================
module mtm_alu_crc3
    import mtm_alu_pkg::*;
#(
    parameter int MSG_W = CRC_MSG_W
) (
    input  logic [MSG_W-1:0] i_msg,
    output logic [2:0]       o_crc
);

    always_comb begin
        o_crc = 3'b000;
        for (int i = MSG_W - 1; i >= 0; i--) begin
            o_crc = crc3_step(o_crc, i_msg[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mtm_alu_serializer.sv
`default_nettype none
// ============================================================================
// Module   : mtm_alu_serializer
// Brief    : MTM ALU output stage; sends a result (4 data + 1 control frame)
//            or an error byte (1 control frame) on the single-wire sout.
//            Define MTM_ALU_SER_IFG_EN for one idle bit between result frames.
// Revision : 1.0 - initial release
// ============================================================================
module mtm_alu_serializer
    import mtm_alu_pkg::*;
#(
    parameter int BIT_W = 8,
    parameter int C_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    input  logic [C_W-1:0]   C,
    input  logic [3:0]       flags,
    input  logic             err_valid,
    input  logic [BIT_W-1:0] err_byte,
    output logic             ready,
    output logic             busy,
    output logic             sout
);

    localparam int                 c_cnt_w    = $clog2(BIT_W);
    localparam logic [2:0]         c_last_res = 3'(RES_FRAMES - 1);
    localparam logic [c_cnt_w-1:0] c_bit_top  = c_cnt_w'(BIT_W - 1);
    localparam logic [c_cnt_w-1:0] c_bit_one  = c_cnt_w'(1);

    logic [2:0]         r_state,     w_state_nxt;
    logic [c_cnt_w-1:0] r_bit_cnt,   w_bit_cnt_nxt;
    logic [2:0]         r_frame_cnt, w_frame_cnt_nxt;
    logic               r_is_err,    w_is_err_nxt;
    logic [C_W-1:0]     r_c,         w_c_nxt;
    logic [3:0]         r_flags,     w_flags_nxt;
    logic [2:0]         r_crc,       w_crc_nxt;
    logic [BIT_W-1:0]   r_shift,     w_shift_nxt;
    logic               r_type,      w_type_nxt;
    logic               r_sout,      w_sout_nxt;
    logic               r_busy;

    logic [2:0]         w_crc_in;
    logic               w_accept;
    logic               w_last_frame;
    logic [2:0]         w_frame_inc;
    logic [BIT_W-1:0]   w_payload;

    mtm_alu_crc3 #(
        .MSG_W (C_W + 5)
    ) u_crc3 (
        .i_msg ({C, 1'b0, flags}),
        .o_crc (w_crc_in)
    );

    assign ready        = (r_state == S_IDLE);
    assign busy         = r_busy;
    assign sout         = r_sout;
    assign w_accept     = ready && (res_valid || err_valid);
    assign w_last_frame = r_is_err || (r_frame_cnt == c_last_res);
    assign w_frame_inc  = r_frame_cnt + 3'd1;

    // Payload for the frame that follows the current one
    always_comb begin
        w_payload = '0;
        case (w_frame_inc)
            3'd0:    w_payload = r_c[4*BIT_W-1 -: BIT_W];
            3'd1:    w_payload = r_c[3*BIT_W-1 -: BIT_W];
            3'd2:    w_payload = r_c[2*BIT_W-1 -: BIT_W];
            3'd3:    w_payload = r_c[BIT_W-1 -: BIT_W];
            default: w_payload = {{(BIT_W-7){1'b0}}, r_flags, r_crc};
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_frame_cnt_nxt = r_frame_cnt;
        w_is_err_nxt    = r_is_err;
        w_c_nxt         = r_c;
        w_flags_nxt     = r_flags;
        w_crc_nxt       = r_crc;
        w_shift_nxt     = r_shift;
        w_type_nxt      = r_type;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt     = S_START;
                    w_frame_cnt_nxt = 3'd0;
                    w_bit_cnt_nxt   = c_bit_top;
                    w_c_nxt         = C;
                    w_flags_nxt     = flags;
                    w_crc_nxt       = w_crc_in;
                    // An error pre-empts a simultaneously offered result
                    if (err_valid) begin
                        w_is_err_nxt = 1'b1;
                        w_type_nxt   = TYPE_CTRL;
                        w_shift_nxt  = err_byte;
                    end else begin
                        w_is_err_nxt = 1'b0;
                        w_type_nxt   = TYPE_DATA;
                        w_shift_nxt  = C[C_W-1 -: BIT_W];
                    end
                end
            end
            S_START: w_state_nxt = S_TYPE;
            S_TYPE: begin
                w_state_nxt   = S_DATA;
                w_bit_cnt_nxt = c_bit_top;
            end
            S_DATA: begin
                if (r_bit_cnt == '0) begin
                    w_state_nxt = S_STOP;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt - c_bit_one;
                    w_shift_nxt   = {r_shift[BIT_W-2:0], 1'b0};
                end
            end
            S_STOP: begin
                if (w_last_frame) begin
                    w_state_nxt = S_IDLE;
                end else begin
`ifdef MTM_ALU_SER_IFG_EN
                    w_state_nxt = S_GAP;
`else
                    w_state_nxt = S_START;
`endif
                    w_frame_cnt_nxt = w_frame_inc;
                    w_shift_nxt     = w_payload;
                    w_type_nxt      = (w_frame_inc == c_last_res) ? TYPE_CTRL : TYPE_DATA;
                end
            end
`ifdef MTM_ALU_SER_IFG_EN
            S_GAP: w_state_nxt = S_START;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // sout is decoded from next-state values so the pin comes straight off a flop
    always_comb begin
        w_sout_nxt = IDLE_LVL;
        case (w_state_nxt)
            S_START: w_sout_nxt = START_LVL;
            S_TYPE:  w_sout_nxt = w_type_nxt;
            S_DATA:  w_sout_nxt = w_shift_nxt[BIT_W-1];
            S_STOP:  w_sout_nxt = STOP_LVL;
            default: w_sout_nxt = IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_frame_cnt <= 3'd0;
            r_is_err    <= 1'b0;
            r_c         <= '0;
            r_flags     <= 4'd0;
            r_crc       <= 3'd0;
            r_shift     <= '0;
            r_type      <= TYPE_DATA;
            r_sout      <= IDLE_LVL;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_is_err    <= w_is_err_nxt;
            r_c         <= w_c_nxt;
            r_flags     <= w_flags_nxt;
            r_crc       <= w_crc_nxt;
            r_shift     <= w_shift_nxt;
            r_type      <= w_type_nxt;
            r_sout      <= w_sout_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mtm_alu_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mtm_alu_serializer
// Brief    : Scoreboard bench for mtm_alu_serializer; honours
//            MTM_ALU_SER_IFG_EN for frame spacing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mtm_alu_serializer;

`ifdef MTM_ALU_SER_IFG_EN
    localparam int STEP     = 12;
    localparam int LAST_OFS = 59;
`else
    localparam int STEP     = 11;
    localparam int LAST_OFS = 55;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        res_valid = 1'b0;
    logic [31:0] C = '0;
    logic [3:0]  flags = '0;
    logic        err_valid = 1'b0;
    logic [7:0]  err_byte = '0;
    logic        ready;
    logic        busy;
    logic        sout;

    int cyc     = 0;
    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [10:0] bits;
        int          st;
    } exp_t;
    exp_t q[$];

    mtm_alu_serializer #(
        .BIT_W (8),
        .C_W   (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .res_valid (res_valid),
        .C         (C),
        .flags     (flags),
        .err_valid (err_valid),
        .err_byte  (err_byte),
        .ready     (ready),
        .busy      (busy),
        .sout      (sout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input logic typ, input logic [7:0] pl, input int st);
        exp_t e;
        e.bits = {1'b0, typ, pl, 1'b1};
        e.st   = st;
        q.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready(output bit ok);
        int guard = 0;
        while (!ready && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        ok = ready;
        if (!ok) begin
            n_total++;
            $display("FAIL accept_timeout: ready stayed %0b, required 1", ready);
        end
    endtask

    task automatic issue_res(input logic [31:0] cv, input logic [3:0] fv, input logic [2:0] crc,
                             input bit wait_done, output int n);
        bit ok;
        res_valid = 1'b1;
        C         = cv;
        flags     = fv;
        wait_ready(ok);
        n = cyc;
        if (!ok) begin
            res_valid = 1'b0;
            return;
        end
        chk("busy_at_accept", busy, 0);
        for (int k = 0; k < 4; k++) push(1'b0, cv[31-8*k -: 8], n + 1 + k*STEP);
        push(1'b1, {1'b0, fv, crc}, n + 1 + 4*STEP);
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        C         = $urandom;
        flags     = 4'($urandom);
        chk("busy_after_accept", busy, 1);
        chk("ready_after_accept", ready, 0);
        if (wait_done) begin
            wait_until(n + LAST_OFS);
            chk("ready_at_last_stop", ready, 0);
            @(posedge clk);
            #1;
            chk("ready_after_packet", ready, 1);
            chk("busy_after_packet", busy, 0);
        end
    endtask

    task automatic issue_err(input logic [7:0] eb, input bit with_res, output int n);
        bit ok;
        err_valid = 1'b1;
        err_byte  = eb;
        res_valid = with_res;
        C         = 32'h12345678;
        flags     = 4'hF;
        wait_ready(ok);
        n = cyc;
        if (!ok) begin
            err_valid = 1'b0;
            res_valid = 1'b0;
            return;
        end
        push(1'b1, eb, n + 1);
        @(posedge clk);
        #1;
        err_valid = 1'b0;
        res_valid = 1'b0;
        chk("err_busy_after_accept", busy, 1);
        wait_until(n + 11);
        chk("err_ready_at_stop", ready, 0);
        @(posedge clk);
        #1;
        chk("err_ready_after", ready, 1);
    endtask

    // Monitor: frames are recognised by their start bit and checked in order
    initial begin : monitor
        logic [10:0] fr;
        int          st;
        bit          abort;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst && sout === 1'b0) begin
                fr    = '0;
                st    = cyc;
                abort = 1'b0;
                for (int i = 9; i >= 0; i--) begin
                    @(negedge clk);
                    if (rst) begin
                        abort = 1'b1;
                        break;
                    end
                    fr[i] = sout;
                end
                if (!abort) begin
                    if (q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_frame: got %03h at cycle %0d, required none", fr, st);
                    end else begin
                        e = q.pop_front();
                        chk("frame_bits", 32'(fr), 32'(e.bits));
                        chk("frame_start_cycle", st, e.st);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        int nb;
        @(posedge clk);
        #1;
        chk("rst_sout", sout, 1);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_sout", sout, 1);

        issue_res(32'h00000000, 4'h0, 3'b000, 1'b1, n);
        issue_res(32'h12345678, 4'b1000, 3'b011, 1'b1, n);
        issue_res(32'h00000001, 4'h0, 3'b010, 1'b1, n);

        issue_err(8'hE1, 1'b1, n);
        issue_err(8'h9A, 1'b0, n);

        // Backpressure: pulse during a packet is dropped, held request lands after it
        issue_res(32'h12345678, 4'b1000, 3'b011, 1'b0, n);
        wait_until(n + 20);
        chk("bp_ready_low", ready, 0);
        res_valid = 1'b1;
        C         = 32'hFFFFFFFF;
        flags     = 4'hF;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        wait_until(n + 22);
        issue_res(32'h00000001, 4'h0, 3'b010, 1'b1, nb);
        chk("bp_accept_cycle", nb, n + LAST_OFS + 1);

        // Reset in the middle of the third frame; only frames 0 and 1 complete
        issue_res(32'hA5A50000, 4'h0, 3'b000, 1'b0, n);
        repeat (3) q.delete(q.size() - 1);
        wait_until(n + 30);
        chk("pre_reset_sout", sout, 0);
        rst = 1'b1;
        #1;
        chk("async_rst_sout", sout, 1);
        chk("async_rst_ready", ready, 1);
        chk("async_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_sout", sout, 1);
            chk("post_rst_ready", ready, 1);
        end

        issue_res(32'hFFFFFFFF, 4'h0, 3'b011, 1'b1, n);

        repeat (20) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mtm_alu_serializer.md
# mtm_alu_serializer

Output stage of the MTM ALU. It accepts either one ALU result (32-bit C plus 4 flags) or one 8-bit error byte. A result is sent on the single-wire serial output as four data frames followed by one control frame carrying the flags and a CRC3. An error is sent as a single control frame. The block sits downstream of the ALU core and the deserializer's error path, and drives the chip's `sout` pin.

## Interface
Parameters:
- `BIT_W`, 8: payload bits per frame.
- `C_W`, 32: result width; must be 4×`BIT_W`.

Ports:
- `clk`  in  1  system clock; one serial bit per cycle.
- `rst`  in  1  asynchronous, active-high reset.
- `res_valid`  in  1  C/flags present; accepted when `ready`=1.
- `C`  in  32  ALU result.
- `flags`  in  4  {carry, overflow, zero, negative}.
- `err_valid`  in  1  error byte present; accepted when `ready`=1.
- `err_byte`  in  8  deserializer control byte {1, crc×2, op×2, data×2, parity}.
- `ready`  out  1  high only in IDLE.
- `busy`  out  1  registered; high from the cycle after accept through the last stop bit.
- `sout`  out  1  serial line, idle high.

## Operation
- Frame format is 11 bits: start `0`, type bit (`0` data / `1` control), 8 payload bits MSB first, stop `1`.
- Result packet:
  - four data frames, C[31:24], C[23:16], C[15:8], C[7:0];
  - then one control frame with payload {0, flags[3:0], crc[2:0]}.
- Error packet: one control frame with payload `err_byte`, passed through unmodified.
- Accept occurs on a cycle with `ready` && (`res_valid` || `err_valid`). `C`, `flags` and `err_byte` are captured into internal registers; inputs are don't-care after the accept cycle.
- If `err_valid` and `res_valid` are both high, the error packet wins and the result is discarded.
- Valid while not ready is ignored. Upstream must hold valid or re-present it.
- CRC3 details:
  - polynomial x³+x+1, init 3'b000;
  - computed over 37 bits {C, 1'b0, flags}, MSB first;
  - computed combinationally from the inputs and registered at accept.
- States:
  - IDLE → START on accept.
  - START (drives 0) → TYPE.
  - TYPE → DATA.
  - DATA (8 cycles, `bit_cnt` 7..0) → STOP.
  - STOP → IDLE when `frame_cnt` = last frame; otherwise START (or GAP, see Configuration).
- `frame_cnt` counts 0..4 for a result and stays 0 for an error. The payload shift register is reloaded in STOP for the next frame.
- Reset value of every output: `sout`=1, `busy`=0, `ready`=1.
- Reset mid-packet: `sout` goes to 1 immediately (asynchronous), the packet is abandoned and the captured data is cleared. No partial frame resumes after reset.

## Timing
- The accept cycle is N.
- First start bit appears at N+1.
- Without IFG: frame k occupies N+1+11k … N+11+11k; last stop bit at N+55 (result) or N+11 (error).
- `ready` returns high the cycle after the last stop bit. The next packet's start bit is therefore at earliest 2 cycles after the previous stop bit, giving at least one idle-high bit between packets.
- `busy` is low on cycle N and high N+1 … last stop bit.

## Configuration
- `MTM_ALU_SER_IFG_EN`
  - Defined: the GAP state inserts one idle-high bit between consecutive frames of a result packet. Frame k starts at N+1+12k and the last stop bit is at N+59.
  - Undefined: frames are back-to-back and the GAP state is not compiled.
- Error packets are unaffected either way.

## Structure
- Shared package `mtm_alu_pkg` holds:
  - state encodings (Gray, 3 bits);
  - frame constants: start/stop levels, type bits, `FRAME_LEN`=11, `RES_FRAMES`=5;
  - flag bit positions;
  - the error-byte field layout, shared with the deserializer;
  - the CRC3 polynomial.
- Sub-module `mtm_alu_crc3`: combinational 37-bit CRC3 generator, reusable by the bench model.

## Test plan
- Basic result: `res_valid` with C=32'h00000000, flags=4'h0 → 55 bits: frames `0 0 00000000 1` ×4, then `0 1 00000000 1`; `ready` high at N+56.
- Byte order: C=32'h12345678, flags=4'b1000 → payloads 12, 34, 56, 78, then control payload {0,1000,crc} with crc equal to the CRC3 model.
- Error packet: `err_valid`, `err_byte`=8'hE1 (crc error) → single frame `0 1 11100001 1`, `ready` high at N+12; simultaneous `res_valid`=1 produces no data frames.
- Backpressure: second `res_valid` pulsed at N+20 → ignored; held until `ready` → accepted at N+56, start bit at N+57.
- Reset mid-frame: assert `rst` at N+30 → `sout`=1 the same cycle; after release, `sout` stays 1 and `ready`=1 until a new accept.
- `MTM_ALU_SER_IFG_EN` build: C=32'hFFFFFFFF → 1 idle-high bit between frames, last stop bit at N+59.
